// File: rtl/gppcu_lane_dispatch.sv
`timescale 1ns/1ps
// Batch lane dispatcher behind the GPPCU priority encoder: one lane index per cycle.
// Define GPPCU_DISPATCH_ROUNDROBIN_EN for rotating selection instead of lowest-index-first.

module gppcu_lane_dispatch_cell (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  input  logic load_val,
  input  logic clr,
  output logic pend
);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     pend <= 1'b0;
    else if (load) pend <= load_val;
    else if (clr)  pend <= 1'b0;
  end
endmodule

module gppcu_lane_dispatch #(
  parameter int EBW = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_VALID,
  input  logic [(1<<EBW)-1:0]   REQ_MASK,
  output logic                  REQ_READY,
  output logic                  GRANT_VALID,
  output logic [EBW-1:0]        GRANT_IDX,
  input  logic                  GRANT_READY,
  output logic [EBW:0]          GRANT_COUNT,
  output logic                  BATCH_DONE,
  output logic                  BUSY
);
  localparam int IBW = 1 << EBW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]     state;
  logic [IBW-1:0] pending, remain, sel_mask;
  logic [EBW-1:0] grant_idx, sel_idx;
  logic [EBW:0]   grant_count;
  logic           accept, take, last;

  assign accept   = (state == S_IDLE) && REQ_VALID;
  assign take     = (state == S_ISSUE) && GRANT_READY;
  // Bitmap left after the lane currently on GRANT_IDX is taken.
  assign remain   = pending & ~(IBW'(1) << grant_idx);
  assign last     = (remain == '0);
  assign sel_mask = (state == S_IDLE) ? REQ_MASK : remain;

  generate
    for (genvar i = 0; i < IBW; i++) begin : g_lane
      gppcu_lane_dispatch_cell u_cell (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (accept),
        .load_val (REQ_MASK[i]),
        .clr      (take && (grant_idx == EBW'(i))),
        .pend     (pending[i])
      );
    end
  endgenerate

`ifdef GPPCU_DISPATCH_ROUNDROBIN_EN
  logic [EBW-1:0] rr_ptr, sel_base, cand;
  logic           found;

  // On a handshake the pointer moves to grant_idx+1 on the same edge, so the
  // follow-on pick already searches from there.
  assign sel_base = (state == S_IDLE) ? rr_ptr : grant_idx + EBW'(1);

  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < IBW; k++) begin
      cand = sel_base + EBW'(k);
      if (!found && sel_mask[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     rr_ptr <= '0;
    else if (take) rr_ptr <= grant_idx + EBW'(1);
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int k = IBW - 1; k >= 0; k--)
      if (sel_mask[k]) sel_idx = EBW'(k);
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_IDLE;
      grant_idx   <= '0;
      grant_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (REQ_VALID) begin
          grant_count <= '0;
          if (|REQ_MASK) begin
            state     <= S_ISSUE;
            grant_idx <= sel_idx;
          end else begin
            state <= S_DONE;
          end
        end
        S_ISSUE: if (GRANT_READY) begin
          grant_count <= grant_count + (EBW+1)'(1);
          if (last) state     <= S_DONE;
          else      grant_idx <= sel_idx;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign REQ_READY   = (state == S_IDLE);
  assign GRANT_VALID = (state == S_ISSUE);
  assign BATCH_DONE  = (state == S_DONE);
  assign BUSY        = (state == S_ISSUE) || (state == S_DONE);
  assign GRANT_IDX   = grant_idx;
  assign GRANT_COUNT = grant_count;

endmodule

// File: tb/tb_gppcu_lane_dispatch.sv
`timescale 1ns/1ps
// Randomized bench for gppcu_lane_dispatch against a queue-based grant-order model.
module tb_gppcu_lane_dispatch;
  localparam int EBW = 4;
  localparam int IBW = 1 << EBW;
`ifdef GPPCU_DISPATCH_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           REQ_VALID = 1'b0;
  logic [IBW-1:0] REQ_MASK = '0;
  logic           REQ_READY;
  logic           GRANT_VALID;
  logic [EBW-1:0] GRANT_IDX;
  logic           GRANT_READY = 1'b0;
  logic [EBW:0]   GRANT_COUNT;
  logic           BATCH_DONE;
  logic           BUSY;

  int n_chk = 0;
  int n_fail = 0;
  int model_ptr = 0;
  int exp_q[$];
  bit last_done = 1'b0;

  gppcu_lane_dispatch #(.EBW(EBW)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_MASK(REQ_MASK),
    .REQ_READY(REQ_READY), .GRANT_VALID(GRANT_VALID), .GRANT_IDX(GRANT_IDX),
    .GRANT_READY(GRANT_READY), .GRANT_COUNT(GRANT_COUNT),
    .BATCH_DONE(BATCH_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Grant order from the rules: repeatedly pick the first requested lane at or
  // above the search base (0 for fixed priority, last grant + 1 for round robin).
  task automatic model_order(input logic [IBW-1:0] mask);
    logic [IBW-1:0] left;
    int p, idx, k;
    left = mask;
    p = RR ? model_ptr : 0;
    exp_q.delete();
    while (left != '0) begin
      k = 0;
      while (!left[(p + k) % IBW]) k++;
      idx = (p + k) % IBW;
      exp_q.push_back(idx);
      left[idx] = 1'b0;
      if (RR) p = (idx + 1) % IBW;
    end
  endtask

  // ready_mode: 0 always ready, 1 random ready. low_cycles forces leading stalls.
  task automatic drive_batch(input logic [IBW-1:0] mask, input int ready_mode,
                             input int low_cycles, input bit hold_req,
                             input int abort_after, input string tag);
    int waited, granted, lows, pc, cyc;
    bit rdy;
    @(negedge CLK);
    if (last_done) begin
      n_chk++;
      if ({REQ_READY, BATCH_DONE, BUSY, GRANT_VALID} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s idle_after_done: rdy/done/busy/gv=%b expected 1000", tag,
                 {REQ_READY, BATCH_DONE, BUSY, GRANT_VALID});
      end
    end
    last_done = 1'b0;
    waited = 0;
    while (REQ_READY !== 1'b1 && waited < 60) begin
      GRANT_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      waited++;
    end
    n_chk++;
    if (REQ_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_ready_timeout: REQ_READY=%b expected 1", tag, REQ_READY);
      return;
    end
    REQ_VALID = 1'b1;
    REQ_MASK  = mask;
    GRANT_READY = 1'($urandom_range(0, 1));
    model_order(mask);
    pc = $countones(mask);
    @(posedge CLK);
    #1;
    if (hold_req) REQ_MASK = '1;
    else          REQ_VALID = 1'b0;
    granted = 0;
    lows = low_cycles;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        n_chk++;
        if ({GRANT_VALID, BATCH_DONE, REQ_READY, BUSY} !== 4'b1001) begin
          n_fail++;
          $display("FAIL %s issue_flags: gv/done/rdy/busy=%b expected 1001 (grant %0d)",
                   tag, {GRANT_VALID, BATCH_DONE, REQ_READY, BUSY}, granted);
        end
        n_chk++;
        if (GRANT_IDX !== EBW'(exp_q[0])) begin
          n_fail++;
          $display("FAIL %s grant_idx: got %0d expected %0d", tag, GRANT_IDX, exp_q[0]);
        end
        n_chk++;
        if (GRANT_COUNT !== (EBW+1)'(granted)) begin
          n_fail++;
          $display("FAIL %s grant_count: got %0d expected %0d", tag, GRANT_COUNT, granted);
        end
        if (granted == abort_after) begin
          GRANT_READY = 1'b0;
          return;
        end
        if (lows > 0) begin
          rdy = 1'b0;
          lows--;
        end else if (ready_mode == 1) rdy = 1'($urandom_range(0, 1));
        else rdy = 1'b1;
        GRANT_READY = rdy;
        if (rdy) begin
          model_ptr = (exp_q[0] + 1) % IBW;
          void'(exp_q.pop_front());
          granted++;
        end
      end else begin
        n_chk++;
        if ({BATCH_DONE, GRANT_VALID, REQ_READY, BUSY} !== 4'b1001) begin
          n_fail++;
          $display("FAIL %s done_flags: done/gv/rdy/busy=%b expected 1001", tag,
                   {BATCH_DONE, GRANT_VALID, REQ_READY, BUSY});
        end
        n_chk++;
        if (GRANT_COUNT !== (EBW+1)'(pc)) begin
          n_fail++;
          $display("FAIL %s done_count: got %0d expected %0d", tag, GRANT_COUNT, pc);
        end
        GRANT_READY = 1'($urandom_range(0, 1));
        last_done = 1'b1;
        break;
      end
    end
    if (cyc >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s batch_timeout: batch not drained in 200 cycles", tag);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_chk++;
    if ({GRANT_VALID, BATCH_DONE, BUSY, REQ_READY} !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s reset_flags: gv/done/busy/rdy=%b expected 0001", tag,
               {GRANT_VALID, BATCH_DONE, BUSY, REQ_READY});
    end
    n_chk++;
    if (GRANT_IDX !== '0 || GRANT_COUNT !== '0) begin
      n_fail++;
      $display("FAIL %s reset_regs: idx=%0d count=%0d expected 0/0", tag, GRANT_IDX, GRANT_COUNT);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    #1;
    check_reset_vals("reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    model_ptr = 0;
    last_done = 1'b0;
  endtask

  task automatic test_basic_drain;
    drive_batch(16'h8421, 0, 0, 1'b0, -1, "basic");
  endtask

  task automatic test_backpressure;
    drive_batch(16'h0006, 0, 3, 1'b0, -1, "backpressure");
  endtask

  task automatic test_empty_full;
    drive_batch(16'h0000, 0, 0, 1'b0, -1, "empty");
    drive_batch(16'hFFFF, 0, 0, 1'b0, -1, "full");
  endtask

  task automatic test_ignored_inputs;
    drive_batch(16'h0003, 1, 1, 1'b1, -1, "ignored_hold");
    drive_batch(16'hFFFF, 1, 0, 1'b0, -1, "ignored_next");
  endtask

  task automatic test_reset_mid_batch;
    drive_batch(16'h00F0, 0, 0, 1'b0, 2, "midreset");
    #2;
    RESET = 1'b1;
    #1;
    check_reset_vals("midreset_async");
    model_ptr = 0;
    exp_q.delete();
    @(posedge CLK);
    #1;
    n_chk++;
    if (BATCH_DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_hold: done=%b busy=%b expected 0/0", BATCH_DONE, BUSY);
    end
    @(negedge CLK);
    RESET = 1'b0;
    last_done = 1'b0;
    drive_batch(16'h0001, 0, 0, 1'b0, -1, "after_reset");
  endtask

  task automatic test_round_robin;
    if (RR) begin
      drive_batch(16'h0003, 0, 0, 1'b0, -1, "rr_a");
      drive_batch(16'h0005, 0, 0, 1'b0, -1, "rr_b");
    end
  endtask

  task automatic test_random;
    logic [IBW-1:0] m;
    for (int t = 0; t < 12; t++) begin
      m = IBW'($urandom);
      if (t % 5 == 4) m = '0;
      drive_batch(m, 1, int'($urandom_range(0, 2)), 1'b0, -1, "random");
    end
  endtask

  task automatic test_back_to_back;
    drive_batch(16'h0010, 0, 0, 1'b0, -1, "b2b_a");
    drive_batch(16'h8001, 0, 0, 1'b0, -1, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_empty_full();
    test_ignored_inputs();
    test_reset_mid_batch();
    test_round_robin();
    test_back_to_back();
    test_random();
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gppcu_lane_dispatch.md
# gppcu_lane_dispatch

Batch dispatcher that sits directly downstream of the GPPCU priority encoder. It captures a lane-request bitmap, repeatedly encodes the highest-priority pending lane, and issues one lane index per cycle over a valid/ready handshake. It clears each lane's bit as it is granted and pulses completion when the batch is drained. It feeds the per-lane execution sequencer with one lane index at a time.

## Interface
Parameters:
- EBW, default 4: encoded index width.
- IBW, fixed at 1 << EBW (localparam, not overridable): lane count and bitmap width.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  a new request batch is offered.
- REQ_MASK  in  IBW  lane bitmap for the offered batch; bit i = lane i requested.
- REQ_READY  out  1  dispatcher accepts a batch; high only in IDLE.
- GRANT_VALID  out  1  GRANT_IDX holds a valid lane index.
- GRANT_IDX  out  EBW  lane index being granted.
- GRANT_READY  in  1  consumer takes the grant.
- GRANT_COUNT  out  EBW+1  grants completed in the current batch.
- BATCH_DONE  out  1  one-cycle pulse after the last grant, or after an empty batch is accepted.
- BUSY  out  1  high in ISSUE and DONE.

## Operation
- State: PENDING register (IBW bits), FSM {IDLE, ISSUE, DONE}, registered grant index, GRANT_COUNT.
- IDLE: REQ_READY=1. On REQ_VALID at an edge: PENDING<=REQ_MASK and GRANT_COUNT<=0.
  - If REQ_MASK != 0: go to ISSUE, GRANT_IDX<=selected lane of REQ_MASK.
  - If REQ_MASK == 0: go to DONE with no grants.
- ISSUE: GRANT_VALID=1.
  - While GRANT_READY=0, GRANT_IDX, PENDING and GRANT_COUNT hold.
  - On a handshake edge: clear PENDING[GRANT_IDX] and increment GRANT_COUNT.
  - If any bits remain, GRANT_IDX<=selected lane of the remaining bitmap and stay in ISSUE, with no bubble.
  - Otherwise go to DONE.
- DONE: BATCH_DONE=1 for exactly one cycle, REQ_READY=0, GRANT_VALID=0; then go to IDLE.
- Selection is combinational over a masked bitmap. The default is the lowest set index; bit 0 has the highest priority.
- A lane is granted exactly once per batch. GRANT_COUNT at BATCH_DONE equals popcount(REQ_MASK). Its maximum is IBW, hence the EBW+1 width.
- REQ_VALID outside IDLE is ignored. Requests are never merged into an active batch.
- GRANT_READY outside ISSUE is ignored.

## Timing
- Reset values:
  - Outputs: GRANT_VALID=0, GRANT_IDX=0, GRANT_COUNT=0, BATCH_DONE=0, BUSY=0, REQ_READY=1.
  - Internal: PENDING=0, FSM=IDLE, round-robin pointer=0.
- Batch accepted at edge N → GRANT_VALID=1 with the first index from N+1.
- Grant taken at edge K with bits remaining → next index valid from K+1, so throughput is one grant per cycle.
- Last grant taken at edge K → BATCH_DONE=1 during cycle K+1, REQ_READY=1 from K+2.
- Minimum batch period is popcount+2 cycles. An empty batch takes 2 cycles (DONE, then IDLE).
- RESET asserted mid-batch: outputs and state return to reset values immediately. The partial batch is lost and no BATCH_DONE is issued.
- All outputs are registered or decoded from state only. There is no combinational path from GRANT_READY or REQ_VALID to any output.

## Configuration
- GPPCU_DISPATCH_ROUNDROBIN_EN defined:
  - A pointer register records (last granted index + 1) mod IBW on every grant handshake.
  - Selection is the first set bit at or above the pointer, wrapping to bit 0.
  - The pointer persists across batches and resets to 0.
- Undefined: fixed lowest-index-first selection, and the pointer register is not instantiated.

## Test plan
- Basic drain (EBW=4, GRANT_READY=1): REQ_MASK=16'h8421 → GRANT_IDX 0,5,10,15 on consecutive cycles; BATCH_DONE one cycle after the 4th grant; GRANT_COUNT=4.
- Backpressure: REQ_MASK=16'h0006, GRANT_READY low for 3 cycles → GRANT_IDX=1 held stable, GRANT_VALID held high; then 1,2 are granted; GRANT_COUNT=2.
- Empty and full batches:
  - REQ_MASK=16'h0000 → no GRANT_VALID; BATCH_DONE in the cycle after acceptance.
  - REQ_MASK=16'hFFFF → 16 grants, indices 0..15; GRANT_COUNT=16.
- Ignored inputs: REQ_VALID=1 with REQ_MASK=16'hFFFF held during an active batch of 16'h0003 → only 0,1 are granted; the new batch is accepted only after returning to IDLE.
- Reset mid-batch: assert RESET after 2 of 4 grants for 16'h00F0 → all outputs go to reset values asynchronously; no BATCH_DONE; the next batch 16'h0001 grants 0.
- Round robin (macro defined): batch 16'h0003 grants 0,1; a following batch 16'h0005 grants 2 then 0.
